md_issue_ctrl: RTL

- Issue and stall controller sitting directly upstream of MD_EX in the E stage.
- Turns the E-stage MD-class instruction into the one-cycle Start pulse and the MDControl code that MD_EX consumes.
- Mirrors MD_EX's busy period with its own latency counter, and generates the D-stage stall for any MD-class instruction (mult/multu/div/divu/mthi/mtlo/mfhi/mflo) while a computation is pending.
- Suppresses issue when E is being flushed by an exception or interrupt.

---
 rtl/md_issue_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/md_issue_ctrl.sv
// Issue/stall controller in front of MD_EX: Start pulse, MDControl code, busy mirror, D-stage stall.
// Latency: Start/MDControl/stall_D are combinational from E-stage inputs; Busy spans MULT_LAT or DIV_LAT cycles.
// Backpressure: stall_D holds any MD-class D-stage instruction while a computation is pending or issuing.
// Optional build macro: MD_DIVZERO_SKIP_EN (div/divu with a zero divisor is not issued).
module md_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_md_use,
  input  logic       ex_valid,
  input  logic [2:0] ex_op,
  input  logic       ex_divisor_zero,
  input  logic       flush,
  output logic       Start,
  output logic [2:0] MDControl,
  output logic       Busy,
  output logic       stall_D,
  output logic       err_sticky
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic live;
  logic is_mul;
  logic is_div;
  logic is_hilo_op;
  logic skip;
  logic go;

`ifdef MD_DIVZERO_SKIP_EN
  // A zero divisor leaves HI/LO untouched, so the divide is simply not issued.
  assign skip = is_div & ex_divisor_zero;
`else
  // Zero divisors issue like any other divide; the operand flag plays no part here.
  assign skip = 1'b0 & ex_divisor_zero;
`endif

  // Decode the E-stage op and form the combinational issue terms.
  always_comb begin
    live       = ex_valid & ~flush;
    is_mul     = (ex_op == 3'd1) | (ex_op == 3'd2);
    is_div     = (ex_op == 3'd3) | (ex_op == 3'd4);
    is_hilo_op = (ex_op >= 3'd1) & (ex_op <= 3'd6);
    go         = live & (state == IDLE);
    Start      = go & (is_mul | is_div) & ~skip;
    MDControl  = (live & is_hilo_op & ~skip) ? ex_op : 3'd0;
    Busy       = (state != IDLE);
    stall_D    = id_md_use & (Busy | Start);
  end

  // Busy-period FSM with latency counter and the sticky dropped-op flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      err_sticky <= 1'b0;
    end else begin
      // Any HI/LO op reaching E while a computation runs is lost.
      if (live & is_hilo_op & (state != IDLE))
        err_sticky <= 1'b1;
      case (state)
        IDLE: begin
          if (Start & is_mul) begin
            state <= MUL_RUN;
            cnt   <= CNT_W'(MULT_LAT);
          end else if (Start & is_div) begin
            state <= DIV_RUN;
            cnt   <= CNT_W'(DIV_LAT);
          end
        end
        MUL_RUN, DIV_RUN: begin
          // A flush while running is ignored: the op has already committed.
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
